exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage MIPS pipeline, between the decode stage and the memory stage. Holds one instruction in a valid/allowin-handshaked pipeline register, drives the combinational `alu` with the latched operands and one-hot `aluop`, and flags signed overflow. Issues the data-SRAM request for loads and stores, and sends the result, a forwarding tap and an exception flag downstream.

## Interface
Parameters:
- none. Widths are fixed by the shared define header.

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  exception/ERET flush from writeback; kills the held instruction
- ds_to_es_valid  in  1  decode offers an instruction
- es_allowin  out  1  stage can accept this cycle
- ds_pc  in  32  instruction PC
- ds_alu_op  in  13  one-hot ALU opcode, passed unchanged to `alu`
- ds_src1 / ds_src2  in  32 each  ALU operands; for shifts src1 = value, src2[4:0] = amount; for LUI src1 = 0, src2 = imm
- ds_dest  in  5  destination GPR
- ds_gr_we / ds_mem_re / ds_mem_we / ds_ov_check  in  1 each  GPR write, load, store, trap-on-overflow (ADD/ADDI/SUB)
- ds_store_data  in  32  store data (rt value)
- es_to_ms_valid  out  1  instruction offered to MEM
- ms_allowin  in  1  MEM can accept
- es_pc, es_result  out  32 each  PC and ALU result
- es_dest  out  5;  es_gr_we, es_mem_re, es_ex  out  1 each
- data_sram_en  out  1;  data_sram_wen  out  4;  data_sram_addr, data_sram_wdata  out  32
- es_fwd_valid  out  1;  es_fwd_dest  out  5;  es_fwd_data  out  32;  es_fwd_is_load  out  1  bypass tap for decode

## Operation
- es_valid register plus latched copies of all ds_* fields. es_ready_go = 1 (single-cycle).
- es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go && !flush.
- Latch all fields when ds_to_es_valid && es_allowin. Stall (es_valid && !ms_allowin) holds every field constant.
- Overflow: es_ex = es_valid && es_ov_check && alu.overflow. When es_ex: es_gr_we = 0, no SRAM access, es_fwd_valid = 0.
- es_result = alu result; is also the SRAM address.
- data_sram_en = es_valid && (es_mem_re || es_mem_we) && ms_allowin && !es_ex && !flush. data_sram_wen = 4'hf for stores (when en), else 4'h0. wdata = store data.
- Forwarding: es_fwd_valid = es_valid && es_gr_we && !es_ex && dest != 0. es_fwd_is_load = es_mem_re, which makes decode stall on load-use.

## Timing
- Reset: es_valid = 0, all latched fields = 0, so every valid-qualified output is 0 and es_allowin = 1.
- Latency is 1 cycle. An instruction accepted at edge N is offered to MEM in cycle N..N+1. Back-to-back issue gives 1 instruction per cycle.
- flush (sampled at the edge) clears es_valid next cycle. It takes priority over a simultaneous capture: the incoming instruction is dropped. It combinationally masks SRAM en and es_to_ms_valid in the same cycle.
- If es_valid && ms_allowin && !ds_to_es_valid, es_valid falls to 0 (bubble).
- resetn low mid-stall drops the instruction immediately (asynchronous). Nothing is issued to SRAM.

## Structure
- Shared define header: ALU op bit indices (SLTU 0, OR 1, ADD 2, SLL 3, LUI 4, SUB 6, SLT 7, AND 8, XOR 9, NOR 10, SRL 11, SRA 12), and bus widths for the DS→ES and ES→MS buses.
- One sub-module: instance of `alu` (vsrc1, vsrc2, aluop, result, overflow). Everything else is in the stage.

## Test plan
- ADD: src1 = 0x7fffffff, src2 = 1, ov_check = 1 → es_ex = 1, es_gr_we = 0, data_sram_en = 0; same with ov_check = 0 (ADDU) → es_result = 0x80000000, es_ex = 0.
- SW: src1 = 0x1000, src2 = 4, store data 0xdeadbeef, ms_allowin = 1 → en = 1, wen = 4'hf, addr = 0x1004, wdata = 0xdeadbeef, for exactly one cycle.
- Stall: ms_allowin low 3 cycles with SRA (src1 = 0x80000000, src2 = 4) → es_allowin = 0, es_result held at 0xf8000000, no new capture.
- Flush with ds_to_es_valid = 1 same edge → next cycle es_valid = 0, es_to_ms_valid = 0, new instruction dropped.
- LW to r5 → es_fwd_valid = 1, es_fwd_dest = 5, es_fwd_is_load = 1; dest = 0 → es_fwd_valid = 0.
- resetn pulsed low mid-cycle while holding an SLTU → all outputs 0 immediately, es_allowin = 1.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcode bit positions,
// the decode-to-execute field bundle and the inter-stage bus widths.
package exe_stage_pkg;

    localparam int ALU_OP_WD = 13;

    localparam int OP_SLTU = 0;
    localparam int OP_OR   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SLL  = 3;
    localparam int OP_LUI  = 4;
    localparam int OP_SUB  = 6;
    localparam int OP_SLT  = 7;
    localparam int OP_AND  = 8;
    localparam int OP_XOR  = 9;
    localparam int OP_NOR  = 10;
    localparam int OP_SRL  = 11;
    localparam int OP_SRA  = 12;

    typedef struct packed {
        logic [31:0]          pc;
        logic [ALU_OP_WD-1:0] alu_op;
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [4:0]           dest;
        logic                 gr_we;
        logic                 mem_re;
        logic                 mem_we;
        logic                 ov_check;
        logic [31:0]          store_data;
    } ds_to_es_bus_t;

    localparam int DS_TO_ES_BUS_WD = $bits(ds_to_es_bus_t);
    // pc + result + dest + gr_we + mem_re + ex
    localparam int ES_TO_MS_BUS_WD = 32 + 32 + 5 + 1 + 1 + 1;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational MIPS ALU driven by a one-hot opcode; flags signed overflow
// for ADD and SUB so the stage can trap when the instruction asks for it.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] aluop,
    input  logic [31:0]          vsrc1,
    input  logic [31:0]          vsrc2,
    output logic [31:0]          result,
    output logic                 overflow
);

    logic        adder_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;
    logic        unused_op;

    assign unused_op = aluop[5];

    // SUB, SLT and SLTU share one adder fed with the inverted second operand.
    assign adder_sub = aluop[OP_SUB] | aluop[OP_SLT] | aluop[OP_SLTU];
    assign adder_b   = adder_sub ? ~vsrc2 : vsrc2;
    assign adder_sum = {1'b0, vsrc1} + {1'b0, adder_b} + {32'd0, adder_sub};

    assign slt_res  = (vsrc1[31] & ~vsrc2[31])
                    | (~(vsrc1[31] ^ vsrc2[31]) & adder_sum[31]);
    assign sltu_res = ~adder_sum[32];

    assign sll_res = vsrc1 << vsrc2[4:0];
    assign srl_res = vsrc1 >> vsrc2[4:0];
    assign sra_res = $signed(vsrc1) >>> vsrc2[4:0];
    assign lui_res = {vsrc2[15:0], 16'd0};

    assign overflow = (aluop[OP_ADD] | aluop[OP_SUB])
                    & ~(vsrc1[31] ^ adder_b[31])
                    & (adder_sum[31] ^ vsrc1[31]);

    assign result = ({32{aluop[OP_ADD] | aluop[OP_SUB]}} & adder_sum[31:0])
                  | ({32{aluop[OP_SLT]}}  & {31'd0, slt_res})
                  | ({32{aluop[OP_SLTU]}} & {31'd0, sltu_res})
                  | ({32{aluop[OP_AND]}}  & (vsrc1 & vsrc2))
                  | ({32{aluop[OP_OR]}}   & (vsrc1 | vsrc2))
                  | ({32{aluop[OP_XOR]}}  & (vsrc1 ^ vsrc2))
                  | ({32{aluop[OP_NOR]}}  & ~(vsrc1 | vsrc2))
                  | ({32{aluop[OP_SLL]}}  & sll_res)
                  | ({32{aluop[OP_SRL]}}  & srl_res)
                  | ({32{aluop[OP_SRA]}}  & sra_res)
                  | ({32{aluop[OP_LUI]}}  & lui_res);

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: one-entry handshaked register,
// ALU, overflow trap, data-SRAM request and a forwarding tap for decode.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 ds_to_es_valid,
    output logic                 es_allowin,
    input  logic [31:0]          ds_pc,
    input  logic [ALU_OP_WD-1:0] ds_alu_op,
    input  logic [31:0]          ds_src1,
    input  logic [31:0]          ds_src2,
    input  logic [4:0]           ds_dest,
    input  logic                 ds_gr_we,
    input  logic                 ds_mem_re,
    input  logic                 ds_mem_we,
    input  logic                 ds_ov_check,
    input  logic [31:0]          ds_store_data,
    output logic                 es_to_ms_valid,
    input  logic                 ms_allowin,
    output logic [31:0]          es_pc,
    output logic [31:0]          es_result,
    output logic [4:0]           es_dest,
    output logic                 es_gr_we,
    output logic                 es_mem_re,
    output logic                 es_ex,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_wen,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    output logic                 es_fwd_valid,
    output logic [4:0]           es_fwd_dest,
    output logic [31:0]          es_fwd_data,
    output logic                 es_fwd_is_load
);

    logic          es_valid;
    logic          es_ready_go;
    ds_to_es_bus_t es_bus;
    logic [31:0]   alu_result;
    logic          alu_overflow;

    assign es_ready_go = 1'b1;
    assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);

    // A flush wins over a same-edge capture, so the incoming instruction is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            es_bus   <= '0;
        end else begin
            if (flush) begin
                es_valid <= 1'b0;
            end else if (es_allowin) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin && !flush) begin
                es_bus <= '{pc:         ds_pc,
                            alu_op:     ds_alu_op,
                            src1:       ds_src1,
                            src2:       ds_src2,
                            dest:       ds_dest,
                            gr_we:      ds_gr_we,
                            mem_re:     ds_mem_re,
                            mem_we:     ds_mem_we,
                            ov_check:   ds_ov_check,
                            store_data: ds_store_data};
            end
        end
    end

    alu u_alu (
        .aluop    (es_bus.alu_op),
        .vsrc1    (es_bus.src1),
        .vsrc2    (es_bus.src2),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    assign es_ex          = es_valid && es_bus.ov_check && alu_overflow;
    assign es_to_ms_valid = es_valid && es_ready_go && !flush;

    assign es_pc     = es_bus.pc;
    assign es_result = alu_result;
    assign es_dest   = es_bus.dest;
    assign es_gr_we  = es_valid && es_bus.gr_we && !es_ex;
    assign es_mem_re = es_valid && es_bus.mem_re;

    // The request only goes out when MEM can take the instruction this cycle.
    assign data_sram_en    = es_valid && (es_bus.mem_re || es_bus.mem_we)
                          && ms_allowin && !es_ex && !flush;
    assign data_sram_wen   = (data_sram_en && es_bus.mem_we) ? 4'hf : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_bus.store_data;

    assign es_fwd_valid   = es_gr_we && (es_bus.dest != 5'd0);
    assign es_fwd_dest    = es_bus.dest;
    assign es_fwd_data    = alu_result;
    assign es_fwd_is_load = es_mem_re;

endmodule

// File: tb/tb_exe_stage.sv
// Directed, table-driven bench for exe_stage plus hand-written sequences
// for stall, flush, single-cycle store and asynchronous reset.
module tb_exe_stage;

    localparam logic [12:0] A_SLTU = 13'h0001;
    localparam logic [12:0] A_OR   = 13'h0002;
    localparam logic [12:0] A_ADD  = 13'h0004;
    localparam logic [12:0] A_SLL  = 13'h0008;
    localparam logic [12:0] A_LUI  = 13'h0010;
    localparam logic [12:0] A_SUB  = 13'h0040;
    localparam logic [12:0] A_SLT  = 13'h0080;
    localparam logic [12:0] A_AND  = 13'h0100;
    localparam logic [12:0] A_XOR  = 13'h0200;
    localparam logic [12:0] A_NOR  = 13'h0400;
    localparam logic [12:0] A_SRL  = 13'h0800;
    localparam logic [12:0] A_SRA  = 13'h1000;

    typedef struct {
        logic [12:0] op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_re;
        logic        mem_we;
        logic        ov;
        logic [31:0] exp_result;
        logic        exp_ex;
        logic        exp_en;
        logic [3:0]  exp_wen;
        logic        exp_fwd;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [12:0] ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ds_mem_re;
    logic        ds_mem_we;
    logic        ds_ov_check;
    logic [31:0] ds_store_data;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_mem_re;
    logic        es_ex;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic [31:0] es_fwd_data;
    logic        es_fwd_is_load;

    int checks;
    int failures;
    vec_t vecs[$];

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_pc           (ds_pc),
        .ds_alu_op       (ds_alu_op),
        .ds_src1         (ds_src1),
        .ds_src2         (ds_src2),
        .ds_dest         (ds_dest),
        .ds_gr_we        (ds_gr_we),
        .ds_mem_re       (ds_mem_re),
        .ds_mem_we       (ds_mem_we),
        .ds_ov_check     (ds_ov_check),
        .ds_store_data   (ds_store_data),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_result       (es_result),
        .es_dest         (es_dest),
        .es_gr_we        (es_gr_we),
        .es_mem_re       (es_mem_re),
        .es_ex           (es_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_valid    (es_fwd_valid),
        .es_fwd_dest     (es_fwd_dest),
        .es_fwd_data     (es_fwd_data),
        .es_fwd_is_load  (es_fwd_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [12:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] sd, input logic [4:0] dest, input logic gr,
                                input logic re, input logic we, input logic ov, input logic [31:0] res,
                                input logic ex, input logic en, input logic [3:0] wen, input logic fwd);
        vec_t v;
        v.op = op; v.src1 = s1; v.src2 = s2; v.sdata = sd; v.dest = dest;
        v.gr_we = gr; v.mem_re = re; v.mem_we = we; v.ov = ov;
        v.exp_result = res; v.exp_ex = ex; v.exp_en = en; v.exp_wen = wen; v.exp_fwd = fwd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input logic [31:0] pc);
        ds_to_es_valid = 1'b1;
        ds_pc          = pc;
        ds_alu_op      = v.op;
        ds_src1        = v.src1;
        ds_src2        = v.src2;
        ds_dest        = v.dest;
        ds_gr_we       = v.gr_we;
        ds_mem_re      = v.mem_re;
        ds_mem_we      = v.mem_we;
        ds_ov_check    = v.ov;
        ds_store_data  = v.sdata;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        flush = 1'b0;
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_pc = '0; ds_alu_op = '0; ds_src1 = '0; ds_src2 = '0; ds_dest = '0;
        ds_gr_we = 1'b0; ds_mem_re = 1'b0; ds_mem_we = 1'b0; ds_ov_check = 1'b0;
        ds_store_data = '0;

        vecs.push_back(mk(A_ADD, 32'h7fffffff, 32'h1, 32'h0, 5'd3, 1, 0, 0, 1, 32'h80000000, 1, 0, 4'h0, 0));
        vecs.push_back(mk(A_ADD, 32'h7fffffff, 32'h1, 32'h0, 5'd3, 1, 0, 0, 0, 32'h80000000, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_ADD, 32'h1000, 32'h4, 32'hdeadbeef, 5'd0, 0, 0, 1, 0, 32'h1004, 0, 1, 4'hf, 0));
        vecs.push_back(mk(A_SRA, 32'h80000000, 32'h4, 32'h0, 5'd7, 1, 0, 0, 0, 32'hf8000000, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_ADD, 32'h2000, 32'h8, 32'h0, 5'd5, 1, 1, 0, 0, 32'h2008, 0, 1, 4'h0, 1));
        vecs.push_back(mk(A_ADD, 32'h2000, 32'h8, 32'h0, 5'd0, 1, 1, 0, 0, 32'h2008, 0, 1, 4'h0, 0));
        vecs.push_back(mk(A_SUB, 32'h80000000, 32'h1, 32'h0, 5'd4, 1, 0, 0, 1, 32'h7fffffff, 1, 0, 4'h0, 0));
        vecs.push_back(mk(A_SLT, 32'hffffffff, 32'h1, 32'h0, 5'd8, 1, 0, 0, 0, 32'h1, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_SLTU, 32'hffffffff, 32'h1, 32'h0, 5'd8, 1, 0, 0, 0, 32'h0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_SLL, 32'h1, 32'h5, 32'h0, 5'd9, 1, 0, 0, 0, 32'h20, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_SRL, 32'h80000000, 32'h4, 32'h0, 5'd9, 1, 0, 0, 0, 32'h08000000, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_LUI, 32'h0, 32'h1234, 32'h0, 5'd10, 1, 0, 0, 0, 32'h12340000, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_NOR, 32'h0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 32'hffffffff, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_XOR, 32'hf0f0f0f0, 32'hff00ff00, 32'h0, 5'd12, 1, 0, 0, 0, 32'h0ff00ff0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_AND, 32'hf0f0f0f0, 32'hff00ff00, 32'h0, 5'd13, 1, 0, 0, 0, 32'hf000f000, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_OR, 32'hf0f0f0f0, 32'h0f0f0000, 32'h0, 5'd14, 1, 0, 0, 0, 32'hfffff0f0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(A_SUB, 32'h5, 32'h7, 32'h0, 5'd2, 1, 0, 0, 1, 32'hfffffffe, 0, 0, 4'h0, 1));

        // Reset state
        #12;
        check_output("reset_allowin", {31'd0, es_allowin}, 32'd1);
        check_output("reset_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        check_output("reset_sram_en", {31'd0, data_sram_en}, 32'd0);
        check_output("reset_fwd_valid", {31'd0, es_fwd_valid}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back vector table
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], 32'hbfc00000 + 32'(i) * 4);
            @(posedge clk); #1;
            check_output($sformatf("v%0d_pc", i), es_pc, 32'hbfc00000 + 32'(i) * 4);
            check_output($sformatf("v%0d_result", i), es_result, vecs[i].exp_result);
            check_output($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].exp_result);
            check_output($sformatf("v%0d_ex", i), {31'd0, es_ex}, {31'd0, vecs[i].exp_ex});
            check_output($sformatf("v%0d_gr_we", i), {31'd0, es_gr_we},
                         {31'd0, vecs[i].gr_we & ~vecs[i].exp_ex});
            check_output($sformatf("v%0d_en", i), {31'd0, data_sram_en}, {31'd0, vecs[i].exp_en});
            check_output($sformatf("v%0d_wen", i), {28'd0, data_sram_wen}, {28'd0, vecs[i].exp_wen});
            check_output($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].sdata);
            check_output($sformatf("v%0d_fwd_valid", i), {31'd0, es_fwd_valid}, {31'd0, vecs[i].exp_fwd});
            check_output($sformatf("v%0d_fwd_dest", i), {27'd0, es_fwd_dest}, {27'd0, vecs[i].dest});
            check_output($sformatf("v%0d_fwd_load", i), {31'd0, es_fwd_is_load}, {31'd0, vecs[i].mem_re});
            check_output($sformatf("v%0d_to_ms", i), {31'd0, es_to_ms_valid}, 32'd1);
        end

        // Store lasts exactly one cycle when followed by a bubble
        apply_stimulus(vecs[2], 32'h00400000);
        @(posedge clk); #1;
        check_output("sw_en", {31'd0, data_sram_en}, 32'd1);
        check_output("sw_wen", {28'd0, data_sram_wen}, 32'hf);
        ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
        check_output("sw_en_after", {31'd0, data_sram_en}, 32'd0);
        check_output("bubble_to_ms", {31'd0, es_to_ms_valid}, 32'd0);

        // Stall: SRA held three cycles while decode offers an ADD
        apply_stimulus(vecs[3], 32'h00400010);
        @(posedge clk); #1;
        ms_allowin = 1'b0;
        apply_stimulus(mk(A_ADD, 32'h1, 32'h1, 32'h0, 5'd6, 1, 0, 0, 0, 32'h2, 0, 0, 4'h0, 1), 32'h00400014);
        #1;
        check_output("stall_allowin", {31'd0, es_allowin}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_output($sformatf("stall%0d_result", c), es_result, 32'hf8000000);
            check_output($sformatf("stall%0d_pc", c), es_pc, 32'h00400010);
            check_output($sformatf("stall%0d_allowin", c), {31'd0, es_allowin}, 32'd0);
            check_output($sformatf("stall%0d_to_ms", c), {31'd0, es_to_ms_valid}, 32'd1);
        end
        ms_allowin = 1'b1;
        @(posedge clk); #1;
        check_output("unstall_result", es_result, 32'h2);
        check_output("unstall_pc", es_pc, 32'h00400014);

        // Flush with a simultaneous capture drops both instructions
        apply_stimulus(vecs[4], 32'h00400020);
        @(posedge clk); #1;
        check_output("pre_flush_en", {31'd0, data_sram_en}, 32'd1);
        flush = 1'b1;
        apply_stimulus(mk(A_ADD, 32'h9, 32'h9, 32'h0, 5'd8, 1, 0, 0, 0, 32'h12, 0, 0, 4'h0, 1), 32'h00400024);
        #1;
        check_output("flush_comb_en", {31'd0, data_sram_en}, 32'd0);
        check_output("flush_comb_to_ms", {31'd0, es_to_ms_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        ds_to_es_valid = 1'b0;
        #1;
        check_output("flush_to_ms", {31'd0, es_to_ms_valid}, 32'd0);
        check_output("flush_gr_we", {31'd0, es_gr_we}, 32'd0);
        check_output("flush_allowin", {31'd0, es_allowin}, 32'd1);
        check_output("flush_pc_not_taken", es_pc, 32'h00400020);
        @(posedge clk); #1;

        // Asynchronous reset while an SLTU is stalled
        apply_stimulus(mk(A_SLTU, 32'h1, 32'h2, 32'h0, 5'd9, 1, 0, 0, 0, 32'h1, 0, 0, 4'h0, 1), 32'h00400030);
        @(posedge clk); #1;
        ms_allowin = 1'b0;
        ds_to_es_valid = 1'b0;
        #2;
        check_output("sltu_held", es_result, 32'h1);
        resetn = 1'b0;
        #1;
        check_output("arst_pc", es_pc, 32'h0);
        check_output("arst_result", es_result, 32'h0);
        check_output("arst_dest", {27'd0, es_dest}, 32'h0);
        check_output("arst_gr_we", {31'd0, es_gr_we}, 32'd0);
        check_output("arst_to_ms", {31'd0, es_to_ms_valid}, 32'd0);
        check_output("arst_en", {31'd0, data_sram_en}, 32'd0);
        check_output("arst_fwd_valid", {31'd0, es_fwd_valid}, 32'd0);
        check_output("arst_allowin", {31'd0, es_allowin}, 32'd1);
        #2;
        resetn = 1'b1;
        ms_allowin = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
